// File: rtl/systolic_dataflow_sequencer.sv
// Dataflow sequencer for a ROWS x COLS systolic MAC array: weight- or output-stationary per job,
// skewed operand buses, and result-matrix assembly from the array's bottom edge.
module systolic_dataflow_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ARRAY_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] top_matrix,
    input  logic [ROWS*ROWS*WORD_SIZE-1:0] left_matrix,
    input  logic [COLS*WORD_SIZE-1:0]      bottom_out,
    output logic                          set_stationary,
    output logic                          stat_bit_in,
    output logic                          fsm_out_select_in,
    output logic [COLS*WORD_SIZE-1:0]      top_in_bus,
    output logic [ROWS*WORD_SIZE-1:0]      left_in_bus,
    output logic                          busy,
    output logic                          result_valid,
    input  logic                          result_ack,
    output logic [ROWS*COLS*WORD_SIZE-1:0] output_matrix
);

    localparam int W       = WORD_SIZE;
    localparam int TS      = 2*ROWS + COLS - 3 + ARRAY_LAT;
    localparam int UL      = ROWS - 1 + ARRAY_LAT;
    localparam int CNT_MAX = (TS > UL) ? TS : UL;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, UNLOAD, DONE} state_t;

    state_t                    state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic                      accept;
    logic                      mode_q;
    logic [ROWS*ROWS*W-1:0]    a_q;
    logic [ROWS*COLS*W-1:0]    b_q;
    logic [ROWS*COLS*W-1:0]    out_q;
    logic                      ws_stream, os_stream;
    int                        cnt_i;

    assign cnt_i     = int'(cnt);
    assign ws_stream = (state == STREAM) && !mode_q;
    assign os_stream = (state == STREAM) && mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = mode ? STREAM : LOAD;
                end
            end
            LOAD: begin
                if (cnt == CNT_W'(ROWS - 1)) begin
                    cnt_d   = '0;
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STREAM: begin
                if (cnt == CNT_W'(TS)) begin
                    cnt_d   = '0;
                    state_d = mode_q ? UNLOAD : DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            UNLOAD: begin
                if (cnt == CNT_W'(UL)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (result_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign set_stationary    = (state == LOAD);
    assign stat_bit_in       = (state == LOAD) || ws_stream;
    assign fsm_out_select_in = (state == UNLOAD);
    assign busy              = (state == LOAD) || (state == STREAM) || (state == UNLOAD);
    assign result_valid      = (state == DONE);
    assign output_matrix     = out_q;

    // Skew windows: element (row, k) appears when the step index equals the sum of its coordinates.
    always_comb begin
        top_in_bus  = '0;
        left_in_bus = '0;
        for (int k = 0; k < ROWS; k++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((state == LOAD) && (cnt_i == ROWS - 1 - k))
                    top_in_bus[c*W +: W] = b_q[(k*COLS + c)*W +: W];
                if (os_stream && (cnt_i == k + c))
                    top_in_bus[c*W +: W] = b_q[(k*COLS + c)*W +: W];
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < ROWS; k++) begin
                if (ws_stream && (cnt_i == r + k))
                    left_in_bus[k*W +: W] = a_q[(r*ROWS + k)*W +: W];
                if (os_stream && (cnt_i == r + k))
                    left_in_bus[r*W +: W] = a_q[(r*ROWS + k)*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            out_q  <= '0;
        end else begin
            if (accept) begin
                a_q    <= left_matrix;
                b_q    <= top_matrix;
                mode_q <= mode;
                out_q  <= '0;
            end
            // WS: row i of column c leaves the bottom edge skewed by its column index.
            for (int i = 0; i < ROWS; i++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (ws_stream && (cnt_i == i + c + ROWS - 1 + ARRAY_LAT))
                        out_q[(i*COLS + c)*W +: W] <= bottom_out[c*W +: W];
                end
            end
            // OS: accumulators shift down, so the bottom row emerges first.
            for (int r = 0; r < ROWS; r++) begin
                if ((state == UNLOAD) && (cnt_i == ROWS - 1 - r + ARRAY_LAT))
                    out_q[r*COLS*W +: COLS*W] <= bottom_out;
            end
        end
    end

endmodule

// File: tb/tb_systolic_dataflow_sequencer.sv
// Randomized bench for systolic_dataflow_sequencer with a matrix-level reference model and
// an array emulator that answers on bottom_out from the operands it sees on the buses.
module tb_systolic_dataflow_sequencer;

    localparam int W         = 16;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int ARRAY_LAT = 1;
    localparam int TS        = 2*ROWS + COLS - 3 + ARRAY_LAT;
    localparam int MW        = ROWS*COLS*W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   mode;
    logic [ROWS*COLS*W-1:0] top_matrix;
    logic [ROWS*ROWS*W-1:0] left_matrix;
    logic [COLS*W-1:0]      bottom_out;
    logic                   set_stationary;
    logic                   stat_bit_in;
    logic                   fsm_out_select_in;
    logic [COLS*W-1:0]      top_in_bus;
    logic [ROWS*W-1:0]      left_in_bus;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ack;
    logic [ROWS*COLS*W-1:0] output_matrix;

    always #5 clk = ~clk;

    systolic_dataflow_sequencer #(
        .WORD_SIZE(W), .ROWS(ROWS), .COLS(COLS), .ARRAY_LAT(ARRAY_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .top_matrix(top_matrix), .left_matrix(left_matrix), .bottom_out(bottom_out),
        .set_stationary(set_stationary), .stat_bit_in(stat_bit_in),
        .fsm_out_select_in(fsm_out_select_in), .top_in_bus(top_in_bus),
        .left_in_bus(left_in_bus), .busy(busy), .result_valid(result_valid),
        .result_ack(result_ack), .output_matrix(output_matrix)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ma   [ROWS][ROWS];
    logic [W-1:0] mb   [ROWS][COLS];
    logic [W-1:0] aobs [ROWS][ROWS];
    logic [W-1:0] bobs [ROWS][COLS];

    task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_now();
        return {set_stationary, stat_bit_in, fsm_out_select_in, busy, result_valid};
    endfunction

    function automatic logic [MW-1:0] rand_vec();
        logic [MW-1:0] v;
        for (int j = 0; j < MW/32; j++) v[j*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [ROWS*ROWS*W-1:0] pack_a();
        logic [ROWS*ROWS*W-1:0] v;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < ROWS; k++) v[(r*ROWS + k)*W +: W] = ma[r][k];
        return v;
    endfunction

    function automatic logic [ROWS*COLS*W-1:0] pack_b();
        logic [ROWS*COLS*W-1:0] v;
        for (int k = 0; k < ROWS; k++)
            for (int c = 0; c < COLS; c++) v[(k*COLS + c)*W +: W] = mb[k][c];
        return v;
    endfunction

    // Reference product C = A * B, modulo 2^W.
    function automatic logic [MW-1:0] ref_c();
        logic [MW-1:0] v;
        logic [W-1:0]  acc;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                acc = '0;
                for (int k = 0; k < ROWS; k++) acc = acc + ma[r][k] * mb[k][c];
                v[(r*COLS + c)*W +: W] = acc;
            end
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, " ctrl"}, MW'(ctrl_now()), '0);
        check_val({tag, " top"}, MW'(top_in_bus), '0);
        check_val({tag, " left"}, MW'(left_in_bus), '0);
        check_val({tag, " matrix"}, output_matrix, '0);
    endtask

    // Runs one job from the current negedge; poke_n injects a stray start, abort_n pulls reset.
    task automatic run_job(input logic m, input int poke_n, input int abort_n, input string name);
        logic [MW-1:0]     exp_c;
        logic [COLS*W-1:0] exp_top, bo;
        logic [ROWS*W-1:0] exp_left;
        logic [W-1:0]      acc;
        int total, fo_cnt, t, u, li, ii, rr;
        bit is_load, is_str, is_unl;
        for (int r = 0; r < ROWS; r++) for (int k = 0; k < ROWS; k++) aobs[r][k] = '0;
        for (int k = 0; k < ROWS; k++) for (int c = 0; c < COLS; c++) bobs[k][c] = '0;
        exp_c       = ref_c();
        left_matrix = pack_a();
        top_matrix  = pack_b();
        mode        = m;
        start       = 1'b1;
        result_ack  = 1'b0;
        @(negedge clk);
        start       = 1'b0;
        left_matrix = rand_vec();
        top_matrix  = rand_vec();
        mode        = 1'($urandom_range(1, 0));
        total  = m ? TS + ROWS + ARRAY_LAT + 1 : ROWS + TS + 1;
        fo_cnt = 0;
        for (int n = 1; n <= total; n++) begin
            if (n == abort_n) begin
                rst = 1'b0;
                #1;
                check_all_zero($sformatf("%s reset n=%0d", name, n));
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_val({name, " idle after reset"}, MW'(ctrl_now()), '0);
                return;
            end
            is_load = 0; is_str = 0; is_unl = 0; t = 0; u = 0; li = 0;
            if (!m) begin
                if (n <= ROWS) begin is_load = 1; li = n - 1; end
                else begin is_str = 1; t = n - ROWS - 1; end
            end else begin
                if (n <= TS + 1) begin is_str = 1; t = n - 1; end
                else begin is_unl = 1; u = n - TS - 2; end
            end
            exp_top  = '0;
            exp_left = '0;
            if (is_load)
                for (int c = 0; c < COLS; c++) exp_top[c*W +: W] = mb[ROWS-1-li][c];
            if (is_str && !m)
                for (int k = 0; k < ROWS; k++)
                    if (t - k >= 0 && t - k < ROWS) exp_left[k*W +: W] = ma[t-k][k];
            if (is_str && m) begin
                for (int c = 0; c < COLS; c++)
                    if (t - c >= 0 && t - c < ROWS) exp_top[c*W +: W] = mb[t-c][c];
                for (int r = 0; r < ROWS; r++)
                    if (t - r >= 0 && t - r < ROWS) exp_left[r*W +: W] = ma[r][t-r];
            end
            check_val($sformatf("%s ctrl n=%0d", name, n), MW'(ctrl_now()),
                      MW'({is_load, is_load | (is_str & !m), is_unl, 1'b1, 1'b0}));
            check_val($sformatf("%s top n=%0d", name, n), MW'(top_in_bus), MW'(exp_top));
            check_val($sformatf("%s left n=%0d", name, n), MW'(left_in_bus), MW'(exp_left));
            fo_cnt += int'(fsm_out_select_in);
            // Array emulator: stationary weights / streamed operands taken from what the buses carry.
            if (is_load)
                for (int c = 0; c < COLS; c++) bobs[ROWS-1-li][c] = top_in_bus[c*W +: W];
            if (is_str && !m)
                for (int k = 0; k < ROWS; k++)
                    if (t - k >= 0 && t - k < ROWS) aobs[t-k][k] = left_in_bus[k*W +: W];
            if (is_str && m) begin
                for (int c = 0; c < COLS; c++)
                    if (t - c >= 0 && t - c < ROWS) bobs[t-c][c] = top_in_bus[c*W +: W];
                for (int r = 0; r < ROWS; r++)
                    if (t - r >= 0 && t - r < ROWS) aobs[r][t-r] = left_in_bus[r*W +: W];
            end
            bo = rand_vec()[COLS*W-1:0];
            if (is_str && !m)
                for (int c = 0; c < COLS; c++) begin
                    ii = t - c - (ROWS - 1) - ARRAY_LAT;
                    if (ii >= 0 && ii < ROWS) begin
                        acc = '0;
                        for (int k = 0; k < ROWS; k++) acc = acc + aobs[ii][k] * bobs[k][c];
                        bo[c*W +: W] = acc;
                    end
                end
            if (is_unl && u >= ARRAY_LAT) begin
                rr = ROWS - 1 - (u - ARRAY_LAT);
                for (int c = 0; c < COLS; c++) begin
                    acc = '0;
                    for (int k = 0; k < ROWS; k++) acc = acc + aobs[rr][k] * bobs[k][c];
                    bo[c*W +: W] = acc;
                end
            end
            bottom_out = bo;
            start = (n == poke_n);
            if (n == poke_n) mode = ~m;
            @(negedge clk);
        end
        start = 1'b0;
        check_val({name, " done ctrl"}, MW'(ctrl_now()), MW'(5'b00001));
        check_val({name, " result"}, output_matrix, exp_c);
        if (m) check_val({name, " unload cycles"}, MW'(fo_cnt), MW'(ROWS + ARRAY_LAT));
        for (int h = 0; h < 2; h++) begin
            start       = 1'b1;
            mode        = ~m;
            left_matrix = rand_vec();
            top_matrix  = rand_vec();
            bottom_out  = rand_vec()[COLS*W-1:0];
            @(negedge clk);
            check_val($sformatf("%s hold ctrl h=%0d", name, h), MW'(ctrl_now()), MW'(5'b00001));
            check_val($sformatf("%s hold result h=%0d", name, h), output_matrix, exp_c);
        end
        result_ack = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        result_ack = 1'b0;
        check_val({name, " idle after ack"}, MW'(ctrl_now()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        mode        = 1'b0;
        result_ack  = 1'b0;
        top_matrix  = '0;
        left_matrix = '0;
        bottom_out  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("in reset");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");

        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check_val("ack in idle", MW'(ctrl_now()), '0);

        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < ROWS; k++) ma[r][k] = (r == k) ? W'(1) : W'(0);
        for (int k = 0; k < ROWS; k++)
            for (int c = 0; c < COLS; c++) mb[k][c] = W'(4*k + c + 1);
        run_job(1'b0, ROWS + 3, -1, "ws ident");
        run_job(1'b1, 3, -1, "os ident");

        for (int r = 0; r < ROWS; r++) for (int k = 0; k < ROWS; k++) ma[r][k] = W'(2);
        for (int k = 0; k < ROWS; k++) for (int c = 0; c < COLS; c++) mb[k][c] = W'(2);
        run_job(1'b0, -1, -1, "ws twos");

        for (int r = 0; r < ROWS; r++) for (int k = 0; k < ROWS; k++) ma[r][k] = W'($urandom());
        for (int k = 0; k < ROWS; k++) for (int c = 0; c < COLS; c++) mb[k][c] = W'($urandom());
        run_job(1'b0, -1, ROWS + 4, "ws abort");
        run_job(1'b0, -1, -1, "ws after abort");

        for (int j = 0; j < 6; j++) begin
            for (int r = 0; r < ROWS; r++) for (int k = 0; k < ROWS; k++) ma[r][k] = W'($urandom());
            for (int k = 0; k < ROWS; k++) for (int c = 0; c < COLS; c++) mb[k][c] = W'($urandom());
            run_job(1'(j % 2), -1, -1, $sformatf("b2b job%0d", j));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
